// File: rtl/unified_mem_ctrl_pkg.sv
// Shared definitions for the unified instruction/data memory controller.
//   - funct3 size/sign encodings used by the core's load/store unit
//   - FSM state encoding for the request/response sequencer
//   - helper functions for sizing the wait-state counter
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Width of a counter able to hold wait_cycles; never narrower than one bit
  // so the zero-wait configuration still elaborates a legal vector.
  function automatic int cnt_w(input int wait_cycles);
    int w;
    w = clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/unified_mem_ctrl_if.sv
// Request/response bus between the core's address mux and the memory.
//   req, we, addr, wdata, funct3 : core -> memory (request side)
//   rdata, ready, misaligned, busy : memory -> core (response side)
// master modport is the core side, slave modport is the memory side.
interface unified_mem_ctrl_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        ready;
  logic        misaligned;
  logic        busy;

  modport master (
    output req, we, addr, wdata, funct3,
    input  rdata, ready, misaligned, busy
  );

  modport slave (
    input  req, we, addr, wdata, funct3,
    output rdata, ready, misaligned, busy
  );

endinterface

// File: rtl/unified_mem_ctrl_load_store_align.sv
// Combinational lane alignment for byte/half/word accesses.
// Ports:
//   off        in  2   byte offset within the word (addr[1:0])
//   funct3     in  3   size/sign code
//   raw        in  32  word read from the array
//   wdata      in  32  right-aligned store data
//   be         out 4   per-byte write enables (0 when misaligned)
//   wdata_sh   out 32  store data replicated onto every candidate lane
//   load_val   out 32  selected lane, sign/zero extended (0 when misaligned)
//   misaligned out 1   access not naturally aligned for its size
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] load_val,
  output logic        misaligned
);

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  logic [7:0]  lane8;
  logic [15:0] lane16;

  // Shift the addressed lane down to bit 0; little-endian byte order.
  assign lane8  = 8'(raw >> {off, 3'b000});
  assign lane16 = 16'(raw >> {off, 3'b000});

  always_comb begin
    be         = 4'b0000;
    wdata_sh   = wdata;
    load_val   = raw;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be       = 4'b0001 << off;
        wdata_sh = {4{wdata[7:0]}};
        load_val = (funct3 == F3_B) ? sext8(lane8) : {24'h0, lane8};
      end
      F3_H, F3_HU: begin
        misaligned = off[0];
        be         = off[1] ? 4'b1100 : 4'b0011;
        wdata_sh   = {2{wdata[15:0]}};
        load_val   = (funct3 == F3_H) ? sext16(lane16) : {16'h0, lane16};
      end
      default: begin
        // lw/sw and the unused codes 011/110/111 all behave as word access.
        misaligned = (off != 2'b00);
        be         = 4'b1111;
        wdata_sh   = wdata;
        load_val   = raw;
      end
    endcase
    if (misaligned) begin
      be       = 4'b0000;
      load_val = 32'h0;
    end
  end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory with req/ready handshake and wait states.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset (control and outputs only;
//               array contents survive)
//   bus    slave modport of unified_mem_ctrl_if:
//            req/we/addr/wdata/funct3 sampled in IDLE only,
//            rdata held from the last response, ready one-cycle pulse,
//            misaligned qualified by ready, busy high in WAIT and RESP.
// Parameters:
//   ADDR_W      word-address width (depth 2**ADDR_W words)
//   WAIT_CYCLES wait states between accept and response (0 allowed)
//   INIT_FILE   optional initial image name
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  unified_mem_ctrl_if.slave bus
);

  localparam int CW    = cnt_w(WAIT_CYCLES);
  localparam int DEPTH = 1 << ADDR_W;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            accept;

  logic            we_p0;
  logic [31:0]     addr_p0;
  logic [31:0]     wdata_p0;
  logic [2:0]      f3_p0;

  logic [31:0]     acc_addr;
  logic [2:0]      acc_f3;
  logic [ADDR_W-1:0] idx;
  logic [31:0]     raw;
  logic [3:0]      be;
  logic [31:0]     wdata_sh;
  logic [31:0]     load_val;
  logic            mis;
  logic [31:0]     rdata_p1;
  logic            wr_en;
  logic            unused_addr;

  logic [31:0]     mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
  end

  assign accept = (state == S_IDLE) && bus.req;

  // ---- FSM state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.req) state_nx = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == CW'(1)) state_nx = S_RESP;
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (accept)           cnt <= CW'(WAIT_CYCLES);
    else if (state == S_WAIT)  cnt <= cnt - CW'(1);
  end

  // ---- stage p0: request latch ----
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.we;
      addr_p0  <= bus.addr;
      wdata_p0 <= bus.wdata;
      f3_p0    <= bus.funct3;
    end
  end

  // The read lookup happens on the edge entering RESP. With zero wait
  // states that edge is the accept edge itself, so the request must be
  // taken straight from the bus instead of the latch.
  assign acc_addr = (state == S_IDLE) ? bus.addr   : addr_p0;
  assign acc_f3   = (state == S_IDLE) ? bus.funct3 : f3_p0;
  assign idx      = acc_addr[ADDR_W+1:2];
  assign raw      = mem[idx];

  // Upper address bits wrap modulo the array depth.
  assign unused_addr = ^acc_addr[31:ADDR_W+2];

  load_store_align u_align (
    .off        (acc_addr[1:0]),
    .funct3     (acc_f3),
    .raw        (raw),
    .wdata      (wdata_p0),
    .be         (be),
    .wdata_sh   (wdata_sh),
    .load_val   (load_val),
    .misaligned (mis)
  );

  // ---- stage p1: response data ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rdata_p1 <= 32'h0;
    else if (state_nx == S_RESP && state != S_RESP)
      rdata_p1 <= load_val;
  end

  // Store commits on the edge leaving RESP; a reset held across that edge
  // has already forced the state back to IDLE, and the gate below covers
  // the same edge explicitly.
  assign wr_en = (state == S_RESP) && we_p0 && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign bus.rdata      = rdata_p1;
  assign bus.ready      = (state == S_RESP);
  assign bus.misaligned = (state == S_RESP) && mis;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_unified_mem_ctrl.sv
module tb_unified_mem_ctrl;
  import mem_pkg::*;

  logic clk;
  logic reset;
  int   nchk;
  int   npass;

  unified_mem_ctrl_if bus();

  unified_mem_ctrl #(
    .ADDR_W      (10),
    .WAIT_CYCLES (2),
    .INIT_FILE   ("")
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  // One transaction, request driven in cycle 0; outputs sampled at each
  // falling edge through the response in cycle 3.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] f3,
                     input logic chk_rd, input logic [31:0] exp_rd,
                     input logic exp_mis);
    @(negedge clk);
    chk({tag, ":busy_c0"}, 32'(bus.busy), 32'd0);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.funct3 = f3;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = 1'b0;
      chk({tag, ":busy"}, 32'(bus.busy), 32'd1);
      chk({tag, ":ready"}, 32'(bus.ready), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) begin
        chk({tag, ":mis"}, 32'(bus.misaligned), 32'(exp_mis));
        if (chk_rd) chk({tag, ":rdata"}, bus.rdata, exp_rd);
      end
    end
  endtask

  initial begin
    nchk = 0; npass = 0;
    reset = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.funct3 = F3_W;
    repeat (3) @(negedge clk);
    chk("rst:ready", 32'(bus.ready), 32'd0);
    chk("rst:busy", 32'(bus.busy), 32'd0);
    chk("rst:mis", 32'(bus.misaligned), 32'd0);
    chk("rst:rdata", bus.rdata, 32'd0);
    reset = 1'b0;

    txn("sw100",  1'b1, 32'h100, 32'hDEADBEEF, F3_W,  1'b0, 32'h0,        1'b0);
    txn("lw100a", 1'b0, 32'h100, 32'h0,        F3_W,  1'b1, 32'hDEADBEEF, 1'b0);
    txn("sb101",  1'b1, 32'h101, 32'h00000080, F3_B,  1'b0, 32'h0,        1'b0);
    txn("lw100b", 1'b0, 32'h100, 32'h0,        F3_W,  1'b1, 32'hDEAD80EF, 1'b0);
    txn("lb101",  1'b0, 32'h101, 32'h0,        F3_B,  1'b1, 32'hFFFFFF80, 1'b0);
    txn("lbu101", 1'b0, 32'h101, 32'h0,        F3_BU, 1'b1, 32'h00000080, 1'b0);
    txn("sh102",  1'b1, 32'h102, 32'h00001234, F3_H,  1'b0, 32'h0,        1'b0);
    txn("lw100c", 1'b0, 32'h100, 32'h0,        F3_W,  1'b1, 32'h123480EF, 1'b0);
    txn("lh102",  1'b0, 32'h102, 32'h0,        F3_H,  1'b1, 32'h00001234, 1'b0);
    txn("lhu100", 1'b0, 32'h100, 32'h0,        F3_HU, 1'b1, 32'h000080EF, 1'b0);
    txn("lh100",  1'b0, 32'h100, 32'h0,        F3_H,  1'b1, 32'hFFFF80EF, 1'b0);
    txn("lb103",  1'b0, 32'h103, 32'h0,        F3_B,  1'b1, 32'h00000012, 1'b0);
    txn("lw103",  1'b0, 32'h103, 32'h0,        F3_W,  1'b1, 32'h00000000, 1'b1);
    txn("lh101",  1'b0, 32'h101, 32'h0,        F3_H,  1'b1, 32'h00000000, 1'b1);
    txn("sw102m", 1'b1, 32'h102, 32'hFFFFFFFF, F3_W,  1'b1, 32'h00000000, 1'b1);
    txn("lw100d", 1'b0, 32'h100, 32'h0,        F3_W,  1'b1, 32'h123480EF, 1'b0);
    txn("lwwrap", 1'b0, 32'h1100, 32'h0,       F3_W,  1'b1, 32'h123480EF, 1'b0);
    txn("f3_011", 1'b0, 32'h100, 32'h0,        3'b011, 1'b1, 32'h123480EF, 1'b0);

    // Store abandoned by a reset pulse during WAIT.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h200; bus.wdata = 32'hCAFEF00D; bus.funct3 = F3_W;
    @(negedge clk);
    bus.req = 1'b0;
    chk("rstw:busy_pre", 32'(bus.busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstw:busy", 32'(bus.busy), 32'd0);
    chk("rstw:ready", 32'(bus.ready), 32'd0);
    chk("rstw:mis", 32'(bus.misaligned), 32'd0);
    chk("rstw:rdata", bus.rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstw:idle", 32'(bus.busy), 32'd0);
    txn("lw200",  1'b0, 32'h200, 32'h0,        F3_W,  1'b1, 32'h00000000, 1'b0);

    // req held high for 12 cycles: accepts at 0, 4, 8.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h100; bus.funct3 = F3_W;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      chk("hold:busy", 32'(bus.busy), ((c % 4) != 0) ? 32'd1 : 32'd0);
      chk("hold:ready", 32'(bus.ready), ((c % 4) == 3) ? 32'd1 : 32'd0);
      if ((c % 4) == 3) chk("hold:rdata", bus.rdata, 32'h123480EF);
    end
    bus.req = 1'b0;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
